// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: clock inhibit, start, 8 data bits LSB first,
// odd parity, stop, device ACK. Timeouts always return the bus to released.

module ps2_host_tx_filt (
  input  logic clk28,
  input  logic rst,
  input  logic pad,
  output logic filt_o
);
  logic [1:0] sync_q;
  logic [2:0] cnt_q;
  logic       filt_q;

  // Filtered level follows the synchronized pad only after 8 consecutive differing samples.
  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
      cnt_q  <= '0;
      filt_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], pad};
      if (sync_q[1] == filt_q) begin
        cnt_q <= '0;
      end else if (cnt_q == 3'd7) begin
        filt_q <= sync_q[1];
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 3'd1;
      end
    end
  end

  assign filt_o = filt_q;
endmodule

module ps2_host_tx #(
  parameter int CLK_FREQ         = 28_000_000,
  parameter int INHIBIT_US       = 120,
  parameter int START_TIMEOUT_US = 15000,
  parameter int PKT_TIMEOUT_US   = 2000
) (
  input  logic       clk28,
  input  logic       rst,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       rx_inhibit,
  output logic       done,
  output logic       ack_ok,
  output logic       err
);
  localparam int CPU = CLK_FREQ / 1_000_000;
  localparam int INH = CPU * INHIBIT_US;
  localparam int STO = CPU * START_TIMEOUT_US;
  localparam int PTO = CPU * PKT_TIMEOUT_US;
  localparam logic [18:0] INH_M1   = 19'(INH - 1);
  localparam logic [18:0] INH_HALF = 19'(INH / 2);
  localparam logic [18:0] STO_M1   = 19'(STO - 1);
  localparam logic [15:0] PTO_M1   = 16'(PTO - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_INHIBIT, S_START, S_DATA, S_PARITY, S_STOP, S_WAITIDLE, S_DONE, S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic [18:0] timer_q, timer_d;
  logic [15:0] pkt_q, pkt_d;
  logic [7:0]  data_q, data_d;
  logic [2:0]  idx_q, idx_d;
  logic        par_q, par_d, drv_q, drv_d, ack_q, ack_d;
  logic        clk_prev_q, clk_filt, dat_filt, clk_fall;

  ps2_host_tx_filt u_clk_filt (.clk28(clk28), .rst(rst), .pad(ps2_clk_in), .filt_o(clk_filt));
  ps2_host_tx_filt u_dat_filt (.clk28(clk28), .rst(rst), .pad(ps2_dat_in), .filt_o(dat_filt));

  assign clk_fall = clk_prev_q & ~clk_filt;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    par_d   = par_q;
    idx_d   = idx_q;
    drv_d   = drv_q;
    ack_d   = ack_q;
    pkt_d   = '0;
    case (state_q)
      S_IDLE: if (tx_valid) begin
        data_d  = tx_data;
        par_d   = ~^tx_data;
        state_d = S_INHIBIT;
      end
      S_INHIBIT: if (timer_q == INH_M1) state_d = S_START;
      S_START: begin
        if (clk_fall) begin
          state_d = S_DATA;
          idx_d   = '0;
          drv_d   = ~data_q[0];
        end else if (timer_q == STO_M1) begin
          state_d = S_ERR;
        end
      end
      S_DATA: begin
        pkt_d = pkt_q + 16'd1;
        if (clk_fall) begin
          if (idx_q == 3'd7) begin
            drv_d   = ~par_q;
            state_d = S_PARITY;
          end else begin
            idx_d = idx_q + 3'd1;
            drv_d = ~data_q[idx_q + 3'd1];
          end
        end
      end
      S_PARITY: begin
        pkt_d = pkt_q + 16'd1;
        if (clk_fall) begin
          drv_d   = 1'b0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        pkt_d = pkt_q + 16'd1;
        if (clk_fall) begin
          ack_d   = dat_filt;
          state_d = S_WAITIDLE;
        end
      end
      S_WAITIDLE: begin
        pkt_d = pkt_q + 16'd1;
        if (clk_filt && dat_filt) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    // Packet timeout wins over any edge seen in the same cycle.
    if ((state_q == S_DATA || state_q == S_PARITY || state_q == S_STOP ||
         state_q == S_WAITIDLE) && pkt_q == PTO_M1)
      state_d = S_ERR;
    timer_d = (state_d != state_q) ? '0 : timer_q + 19'd1;
  end

  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      pkt_q      <= '0;
      data_q     <= '0;
      idx_q      <= '0;
      par_q      <= 1'b0;
      drv_q      <= 1'b0;
      ack_q      <= 1'b1;
      clk_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      pkt_q      <= pkt_d;
      data_q     <= data_d;
      idx_q      <= idx_d;
      par_q      <= par_d;
      drv_q      <= drv_d;
      ack_q      <= ack_d;
      clk_prev_q <= clk_filt;
    end
  end

  // Outputs decode registers only; reset forces IDLE so both lines release at once.
  assign tx_ready   = (state_q == S_IDLE);
  assign rx_inhibit = (state_q != S_IDLE);
  assign ps2_clk_oe = (state_q == S_INHIBIT);
  assign ps2_dat_oe = (state_q == S_INHIBIT && timer_q >= INH_HALF) || (state_q == S_START) ||
                      ((state_q == S_DATA || state_q == S_PARITY) && drv_q);
  assign done       = (state_q == S_DONE);
  assign ack_ok     = (state_q == S_DONE) && !ack_q;
  assign err        = (state_q == S_ERR);
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: keyboard device model on an open-drain bus, frame scoreboard
// and a per-cycle handshake/bus-release check.

module tb_ps2_host_tx;
  localparam int INH = 120;
  localparam int STO = 15000;
  localparam int PTO = 2000;

  logic       clk28 = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       dev_clk_rel = 1'b1, dev_dat_rel = 1'b1, glitch = 1'b0;
  logic       ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
  logic       tx_ready, rx_inhibit, done, ack_ok, err;

  assign ps2_clk_in = !ps2_clk_oe && dev_clk_rel && !glitch;
  assign ps2_dat_in = !ps2_dat_oe && dev_dat_rel;

  ps2_host_tx #(.CLK_FREQ(1_000_000), .INHIBIT_US(120), .START_TIMEOUT_US(15000),
                .PKT_TIMEOUT_US(2000)) dut (
    .clk28(clk28), .rst(rst), .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_inhibit(rx_inhibit), .done(done), .ack_ok(ack_ok), .err(err));

  always #5 clk28 = ~clk28;

  int cyc = 0;
  always @(posedge clk28) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  int n_done = 0, n_err = 0, done_cyc = 0, err_cyc = 0;
  logic last_ack = 1'b0;
  logic busy_m;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input longint act, input longint lo, input longint hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Expected wire frame: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] frame_of(input logic [7:0] d);
    logic par;
    par = ($countones(d) % 2 == 0);
    return {1'b1, par, d, 1'b0};
  endfunction

  // Transaction-level model: busy from an accepted request until the cycle after done/err.
  always @(posedge clk28 or posedge rst) begin
    if (rst) busy_m <= 1'b0;
    else if (!busy_m && tx_valid) busy_m <= 1'b1;
    else if (busy_m && (done || err)) busy_m <= 1'b0;
  end

  always @(negedge clk28) begin
    checks++;
    if (!((rx_inhibit == busy_m) && (tx_ready == !busy_m) && !(done && err) &&
          (busy_m || (!ps2_clk_oe && !ps2_dat_oe)) && (!ack_ok || done))) begin
      errors++;
      $display("FAIL cycle_check @%0d: busy_model=%0b ready=%0b inhibit=%0b clk_oe=%0b dat_oe=%0b done=%0b ack_ok=%0b err=%0b",
               cyc, busy_m, tx_ready, rx_inhibit, ps2_clk_oe, ps2_dat_oe, done, ack_ok, err);
    end
    if (done) begin n_done++; last_ack = ack_ok; done_cyc = cyc; end
    if (err) begin n_err++; err_cyc = cyc; end
  end

  task automatic device(input int nclk, input bit ack_low, input bit glitchy,
                        output logic [10:0] bits, output int inh_len, output int dlow,
                        output int fall_cyc);
    int t;
    bits = '1; inh_len = 0; dlow = 0; fall_cyc = -1; t = 0;
    while (!ps2_clk_oe && t < 50) begin @(negedge clk28); t++; end
    if (!ps2_clk_oe) return;
    while (ps2_clk_oe && inh_len < 5000) begin
      if (!ps2_dat_in) dlow++;
      inh_len++;
      @(negedge clk28);
    end
    bits[0] = ps2_dat_in;
    repeat (30) @(negedge clk28);
    for (int i = 1; i <= nclk; i++) begin
      dev_clk_rel = 1'b0;
      if (i == 1) fall_cyc = cyc;
      repeat (40) @(negedge clk28);
      if (i <= 10) bits[i] = ps2_dat_in;
      dev_clk_rel = 1'b1;
      if (i == 11) begin
        repeat (5) @(negedge clk28);
        dev_dat_rel = 1'b1;
      end else begin
        for (int k = 0; k < 40; k++) begin
          if (glitchy && k == 18) glitch = 1'b1;
          if (k == 21) glitch = 1'b0;
          if (i == 10 && ack_low && k == 5) dev_dat_rel = 1'b0;
          @(negedge clk28);
        end
      end
    end
  endtask

  task automatic send(input logic [7:0] d, output int acc);
    @(negedge clk28);
    chk("ready_before_send", tx_ready, 1);
    tx_data = d;
    tx_valid = 1'b1;
    @(posedge clk28);
    #1;
    acc = cyc;
    tx_valid = 1'b0;
    tx_data = 8'($urandom);
    @(negedge clk28);
    chk("clk_oe_after_accept", ps2_clk_oe, 1);
  endtask

  task automatic wait_end(input int bound, output bit timed_out);
    int nd, ne;
    nd = n_done; ne = n_err; timed_out = 1'b1;
    for (int t = 0; t < bound; t++) begin
      @(negedge clk28);
      #1;
      if (n_done != nd || n_err != ne) begin timed_out = 1'b0; break; end
    end
  endtask

  logic [10:0] r_bits;
  int r_inh, r_dlow, r_fall, r_acc, r_nd, r_ne;
  bit r_to;

  task automatic run_frame(input logic [7:0] d, input int nclk, input bit ack_low,
                           input bit glitchy, input bit poke);
    logic [10:0] bits;
    int inh, dl, fc, acc, nd0, ne0;
    bit to;
    nd0 = n_done; ne0 = n_err;
    fork
      device(nclk, ack_low, glitchy, bits, inh, dl, fc);
      begin send(d, acc); wait_end(20000, to); end
      begin
        if (poke) begin
          repeat (300) @(negedge clk28);
          tx_data = ~d; tx_valid = 1'b1;
          @(negedge clk28);
          tx_valid = 1'b0;
        end
      end
    join
    r_bits = bits; r_inh = inh; r_dlow = dl; r_fall = fc; r_acc = acc; r_to = to;
    r_nd = n_done - nd0; r_ne = n_err - ne0;
    chk("end_timeout", r_to, 0);
  endtask

  task automatic check_frame(input logic [7:0] d, input bit ack_low);
    chk("inhibit_len", r_inh, INH);
    chk("inhibit_data_low", r_dlow, INH - INH / 2);
    chk("frame_bits", r_bits, frame_of(d));
    chk("done_count", r_nd, 1);
    chk("err_count", r_ne, 0);
    chk("ack_ok", last_ack, ack_low);
  endtask

  initial begin
    logic [10:0] bits;
    int inh, dl, fc, acc;
    logic [7:0] d;
    bit a;

    repeat (3) @(negedge clk28);
    chk("rst_clk_oe", ps2_clk_oe, 0);
    chk("rst_dat_oe", ps2_dat_oe, 0);
    chk("rst_done", done, 0);
    chk("rst_ack_ok", ack_ok, 0);
    chk("rst_err", err, 0);
    chk("rst_rx_inhibit", rx_inhibit, 0);
    chk("rst_tx_ready", tx_ready, 1);
    rst = 1'b0;
    repeat (5) @(negedge clk28);

    run_frame(8'hED, 11, 1'b1, 1'b0, 1'b0);
    check_frame(8'hED, 1'b1);
    chk("frame_ED_literal", r_bits, 11'h7DA);

    run_frame(8'h00, 11, 1'b1, 1'b0, 1'b0);
    check_frame(8'h00, 1'b1);
    chk("frame_00_literal", r_bits, 11'h600);

    run_frame(8'h5A, 11, 1'b0, 1'b0, 1'b0);
    check_frame(8'h5A, 1'b0);

    run_frame(8'hF3, 0, 1'b1, 1'b0, 1'b0);
    chk("start_to_err", r_ne, 1);
    chk("start_to_no_done", r_nd, 0);
    chk_rng("start_to_latency", err_cyc - r_acc, INH + STO - 1, INH + STO + 1);
    @(negedge clk28);
    chk("start_to_released", {ps2_clk_oe, ps2_dat_oe, tx_ready}, 3'b001);

    run_frame(8'hA5, 5, 1'b1, 1'b0, 1'b0);
    chk("pkt_to_err", r_ne, 1);
    chk("pkt_to_no_done", r_nd, 0);
    chk_rng("pkt_to_latency", err_cyc - r_fall, PTO + 5, PTO + 15);
    @(negedge clk28);
    chk("pkt_to_released", {ps2_clk_oe, ps2_dat_oe, tx_ready}, 3'b001);

    run_frame(8'h3C, 11, 1'b1, 1'b1, 1'b0);
    check_frame(8'h3C, 1'b1);

    fork
      device(4, 1'b1, 1'b0, bits, inh, dl, fc);
      send(8'h00, acc);
    join
    repeat (10) @(negedge clk28);
    chk("mid_data_busy", rx_inhibit, 1);
    chk("mid_data_dat_oe", ps2_dat_oe, 1);
    @(posedge clk28);
    #3 rst = 1'b1;
    #1;
    chk("rst_mid_clk_oe", ps2_clk_oe, 0);
    chk("rst_mid_dat_oe", ps2_dat_oe, 0);
    chk("rst_mid_tx_ready", tx_ready, 1);
    repeat (3) @(negedge clk28);
    rst = 1'b0;
    repeat (5) @(negedge clk28);
    run_frame(8'hFF, 11, 1'b1, 1'b0, 1'b0);
    check_frame(8'hFF, 1'b1);

    for (int n = 0; n < 6; n++) begin
      d = 8'($urandom);
      a = 1'($urandom_range(0, 1));
      run_frame(d, 11, a, 1'($urandom_range(0, 1)), n == 2);
      check_frame(d, a);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
